timer_counter: RTL and testbench



---
 rtl/timer_counter.sv | 159 +++++++++++++++
 tb/tb_timer_counter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - memory-mapped countdown timer with one-shot / auto-reload IRQ
//
// Purpose: countdown timer on the bridge DEV0 port. The CPU programs a preset and
// a control word; the timer loads the preset, counts down to zero, then raises
// an interrupt flag and either stops (one-shot) or reloads (auto-reload).
//
// Ports:
//   clk    in   1   system clock, all state updates on the rising edge
//   rst_n  in   1   synchronous active-low reset
//   Addr   in  32   device address, only Addr[3:2] decoded
//                   (0 CTRL, 1 PRESET, 2 COUNT, 3 reserved)
//   WD     in  32   write data
//   Wr     in   1   write strobe, one cycle per write
//   BE     in   4   byte enables, BE[i] gates byte i of a write
//   RD     out 32   read data, combinational from Addr[3:2]
//   IRQ    out  1   interrupt request, CTRL.IM & irq_flag

module timer_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Addr,
  input  logic [31:0] WD,
  input  logic        Wr,
  input  logic [3:0]  BE,
  output logic [31:0] RD,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        ctrl_en;
  logic [1:0]  ctrl_mode;
  logic        ctrl_im;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;

  logic [1:0]  sel;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        auto_mode;

  logic        do_load;
  logic        do_dec;
  logic        do_expire;
  logic        do_oneshot_clr;
  logic        do_reload;

  // Address bits outside [3:2] are decoded upstream by the bridge.
  logic        unused_addr;
  assign unused_addr = ^{Addr[31:4], Addr[1:0]};

  assign sel       = Addr[3:2];
  assign wr_ctrl   = Wr && (sel == 2'd0);
  assign wr_preset = Wr && (sel == 2'd1);
  // MODE 10/11 behave as one-shot.
  assign auto_mode = (ctrl_mode == 2'b01);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; EN=0 in any active state drops back to IDLE with COUNT held.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: state_next = ctrl_en ? S_LOAD : S_IDLE;
      S_LOAD: state_next = ctrl_en ? S_CNT : S_IDLE;
      S_CNT: begin
        if (!ctrl_en)             state_next = S_IDLE;
        else if (count <= 32'd1)  state_next = S_INT;
        else                      state_next = S_CNT;
      end
      S_INT: state_next = (ctrl_en && auto_mode) ? S_LOAD : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Per-state datapath actions
  always_comb begin
    do_load        = 1'b0;
    do_dec         = 1'b0;
    do_expire      = 1'b0;
    do_oneshot_clr = 1'b0;
    do_reload      = 1'b0;
    case (state)
      S_LOAD: do_load = ctrl_en;
      S_CNT: begin
        do_dec    = ctrl_en && (count > 32'd1);
        do_expire = ctrl_en && (count <= 32'd1);
      end
      S_INT: begin
        do_oneshot_clr = ctrl_en && !auto_mode;
        do_reload      = ctrl_en && auto_mode;
      end
      default: ;
    endcase
  end

  // Registers. Later assignments take priority, so a CPU CTRL write beats the
  // one-shot EN clear, and any CTRL/PRESET write clears the flag last.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_en   <= 1'b0;
      ctrl_mode <= 2'b00;
      ctrl_im   <= 1'b0;
      preset    <= 32'd0;
      count     <= 32'd0;
      irq_flag  <= 1'b0;
    end else begin
      if (do_load)   count <= preset;
      if (do_dec)    count <= count - 32'd1;
      if (do_expire) count <= 32'd0;

      if (do_oneshot_clr) ctrl_en <= 1'b0;
      if (wr_ctrl && BE[0]) begin
        ctrl_en   <= WD[0];
        ctrl_mode <= WD[2:1];
        ctrl_im   <= WD[3];
      end

      if (wr_preset) begin
        for (int i = 0; i < 4; i++) begin
          if (BE[i]) preset[8*i +: 8] <= WD[8*i +: 8];
        end
      end

      if (do_expire) irq_flag <= 1'b1;
      if (do_reload) irq_flag <= 1'b0;
      if (wr_ctrl || wr_preset) irq_flag <= 1'b0;
    end
  end

  always_comb begin
    RD = 32'd0;
    case (sel)
      2'd0:    RD = {28'd0, ctrl_im, ctrl_mode, ctrl_en};
      2'd1:    RD = preset;
      2'd2:    RD = count;
      default: RD = 32'd0;
    endcase
  end

  assign IRQ = ctrl_im & irq_flag;

endmodule

// File: tb/tb_timer_counter.sv
// tb/tb_timer_counter.sv - directed scoreboard bench for timer_counter

module tb_timer_counter;

  logic        clk;
  logic        rst_n;
  logic [31:0] Addr;
  logic [31:0] WD;
  logic        Wr;
  logic [3:0]  BE;
  logic [31:0] RD;
  logic        IRQ;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] addr;
    logic [31:0] rd;
    logic        irq;
  } exp_t;

  exp_t sb[$];

  timer_counter dut (
    .clk  (clk),
    .rst_n(rst_n),
    .Addr (Addr),
    .WD   (WD),
    .Wr   (Wr),
    .BE   (BE),
    .RD   (RD),
    .IRQ  (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] A_CTRL = 32'h7f00;
  localparam logic [31:0] A_PRE  = 32'h7f04;
  localparam logic [31:0] A_CNT  = 32'h7f08;
  localparam logic [31:0] A_RSV  = 32'h7f0c;

  // Advance one rising edge, land 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    Addr = a;
    WD   = d;
    BE   = be;
    Wr   = 1'b1;
    tick();
    Wr   = 1'b0;
    BE   = 4'h0;
    WD   = 32'h0;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] a,
                            input logic [31:0] rd, input logic irq);
    exp_t e;
    e.tag  = tag;
    e.addr = a;
    e.rd   = rd;
    e.irq  = irq;
    sb.push_back(e);
  endtask

  // Pop the oldest expectation, present its address and compare.
  task automatic check_out();
    exp_t e;
    e = sb.pop_front();
    Addr = e.addr;
    #1;
    checks++;
    assert (RD === e.rd) else begin
      errors++;
      $error("FAIL %s RD: observed %h expected %h", e.tag, RD, e.rd);
    end
    checks++;
    assert (IRQ === e.irq) else begin
      errors++;
      $error("FAIL %s IRQ: observed %b expected %b", e.tag, IRQ, e.irq);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] a,
                     input logic [31:0] rd, input logic irq);
    expect_out(tag, a, rd, irq);
    check_out();
  endtask

  // Bounded wait for IRQ; returns the number of edges taken (budget+1 on timeout).
  task automatic wait_irq(input int budget, output int n);
    n = 0;
    while (n < budget) begin
      tick();
      n++;
      if (IRQ === 1'b1) return;
    end
    n = budget + 1;
  endtask

  logic [31:0] ar_cnt [5] = '{32'd2, 32'd1, 32'd0, 32'd0, 32'd3};
  logic        ar_irq [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    int n;
    rst_n = 1'b0;
    Addr  = 32'h0;
    WD    = 32'h0;
    Wr    = 1'b0;
    BE    = 4'h0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("reset_ctrl",   A_CTRL, 32'h0, 1'b0);
    chk("reset_preset", A_PRE,  32'h0, 1'b0);
    chk("reset_count",  A_CNT,  32'h0, 1'b0);

    // One-shot, preset 5
    write(A_PRE, 32'd5, 4'hF);
    write(A_CTRL, 32'h9, 4'hF);
    chk("os_idle_count", A_CNT, 32'd0, 1'b0);
    tick();
    tick();
    chk("os_count5", A_CNT, 32'd5, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("os_countdown", A_CNT, 32'd5 - k, 1'b0);
    end
    tick();
    chk("os_zero_irq", A_CNT, 32'd0, 1'b1);
    tick();
    chk("os_ctrl_after_int", A_CTRL, 32'h8, 1'b1);
    tick();
    chk("os_irq_sticky", A_CNT, 32'd0, 1'b1);
    write(A_PRE, 32'd7, 4'hF);
    chk("os_irq_cleared", A_PRE, 32'd7, 1'b0);

    // Reset mid-count, with a same-edge write that must lose
    write(A_PRE, 32'd20, 4'hF);
    write(A_CTRL, 32'h9, 4'hF);
    repeat (4) tick();
    rst_n = 1'b0;
    write(A_PRE, 32'h55, 4'hF);
    tick();
    rst_n = 1'b1;
    chk("rst_mid_ctrl",   A_CTRL, 32'h0, 1'b0);
    chk("rst_mid_preset", A_PRE,  32'h0, 1'b0);
    chk("rst_mid_count",  A_CNT,  32'h0, 1'b0);
    write(A_PRE, 32'd2, 4'hF);
    repeat (3) tick();
    chk("rst_stays_idle", A_CNT, 32'h0, 1'b0);

    // Byte enables, read-only COUNT, reserved offset, CTRL upper bits
    write(A_PRE, 32'hAABBCCDD, 4'hF);
    write(A_PRE, 32'h11223344, 4'b0101);
    chk("be_preset", A_PRE, 32'hAA22CC44, 1'b0);
    write(A_CNT, 32'hFFFFFFFF, 4'hF);
    chk("count_ro", A_CNT, 32'h0, 1'b0);
    write(A_RSV, 32'hFFFFFFFF, 4'hF);
    chk("reserved", A_RSV, 32'h0, 1'b0);
    write(A_CTRL, 32'hFFFFFFF0, 4'hF);
    chk("ctrl_upper", A_CTRL, 32'h0, 1'b0);

    // Auto-reload, preset 3, period 5
    write(A_PRE, 32'd3, 4'hF);
    write(A_CTRL, 32'hB, 4'hF);
    tick();
    tick();
    chk("ar_count3", A_CNT, 32'd3, 1'b0);
    for (int p = 0; p < 4; p++) begin
      for (int j = 0; j < 5; j++) begin
        tick();
        chk("ar_period", A_CNT, ar_cnt[j], ar_irq[j]);
      end
    end
    write(A_CTRL, 32'h0, 4'hF);
    tick();
    chk("ar_stop_hold", A_CNT, 32'd2, 1'b0);

    // Disable mid-count at COUNT=6, then re-enable
    write(A_PRE, 32'd10, 4'hF);
    write(A_CTRL, 32'h9, 4'hF);
    repeat (5) tick();
    write(A_CTRL, 32'h0, 4'hF);
    chk("dis_count6", A_CNT, 32'd6, 1'b0);
    repeat (3) tick();
    chk("dis_frozen", A_CNT, 32'd6, 1'b0);
    write(A_CTRL, 32'h9, 4'hF);
    tick();
    tick();
    chk("reen_reload", A_CNT, 32'd10, 1'b0);
    write(A_CTRL, 32'h0, 4'hF);
    tick();

    // Preset 0 reaches INT one cycle after LOAD
    write(A_PRE, 32'd0, 4'hF);
    write(A_CTRL, 32'h9, 4'hF);
    tick();
    tick();
    chk("p0_cnt_state", A_CNT, 32'd0, 1'b0);
    tick();
    chk("p0_int_irq", A_CNT, 32'd0, 1'b1);
    tick();
    chk("p0_ctrl", A_CTRL, 32'h8, 1'b1);
    write(A_PRE, 32'd0, 4'hF);
    chk("p0_clear", A_CNT, 32'd0, 1'b0);

    // Mask: flag set internally with IM=0, IM write clears it
    write(A_CTRL, 32'h1, 4'hF);
    repeat (3) tick();
    chk("mask_int", A_CNT, 32'd0, 1'b0);
    tick();
    chk("mask_ctrl", A_CTRL, 32'h0, 1'b0);
    write(A_CTRL, 32'h8, 4'hF);
    chk("mask_im_set", A_CTRL, 32'h8, 1'b0);

    // CPU CTRL write on the one-shot INT action edge wins
    write(A_PRE, 32'd2, 4'hF);
    write(A_CTRL, 32'h9, 4'hF);
    repeat (3) tick();
    chk("race_pre_int", A_CNT, 32'd1, 1'b0);
    tick();
    chk("race_int", A_CNT, 32'd0, 1'b1);
    write(A_CTRL, 32'h9, 4'hF);
    chk("race_ctrl_wins", A_CTRL, 32'h9, 1'b0);
    tick();
    tick();
    chk("race_reload", A_CNT, 32'd2, 1'b0);
    wait_irq(10, n);
    checks++;
    assert (n === 2) else begin
      errors++;
      $error("FAIL race_irq_latency: observed %0d expected %0d", n, 2);
    end
    write(A_CTRL, 32'h0, 4'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
